// File: rtl/btn_cmd_conditioner.sv
// Push-button front end for the up/down counter: synchronise, debounce, edge-detect,
// hold-to-repeat for up/down, and run-mode continuous count-up, emitting exclusive command pulses.
module btn_cmd_conditioner #(
    parameter int DB_TICKS   = 4,
    parameter int RPT_DELAY  = 32,
    parameter int RPT_PERIOD = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       btn_up_i,
    input  logic       btn_dw_i,
    input  logic       btn_ld_i,
    input  logic       btn_run_i,
    input  logic       at_top_i,
    output logic       up_o,
    output logic       dw_o,
    output logic       ld_o,
    output logic [3:0] held_o
);

    localparam int DB_W    = $clog2(DB_TICKS + 1);
    localparam int TMR_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    logic [3:0]      raw_s;
    logic [3:0]      sync1_r;
    logic [3:0]      sync2_r;
    logic [3:0]      stable_r;
    logic [2:0]      stable_q_r;
    logic [3:0]      armed_r;
    logic [1:0]      boot_r;
    logic [DB_W-1:0] db_cnt_r  [4];
    logic [DB_W-1:0] arm_cnt_r [4];

    logic [2:0]       rise_s;
    logic             conflict_s;
    logic             run_req_s;
    logic             dir_held_s;
    logic [TMR_W-1:0] timer_inc_s;

    state_t           state_r, state_n;
    logic             dir_r, dir_n;
    logic [TMR_W-1:0] timer_r, timer_n;
    logic             fsm_up_s, fsm_dw_s;
    logic             up_n, dw_n, ld_n;

    assign raw_s  = {btn_run_i, btn_ld_i, btn_dw_i, btn_up_i};
    assign held_o = stable_r;

    // Two-flop synchronisers, edge-detect history and post-reset settle flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r    <= 4'b0000;
            sync2_r    <= 4'b0000;
            stable_q_r <= 3'b000;
            boot_r     <= 2'b00;
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            stable_q_r <= stable_r[2:0];
            boot_r     <= {boot_r[0], 1'b1};
        end
    end

    // Per-button debounce; a button only becomes armed once a released level has been
    // debounced after reset, so a press held through reset never produces a pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_r <= 4'b0000;
            armed_r  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i]  <= '0;
                arm_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (tick_i) begin
                    if (db_cnt_r[i] == DB_W'(DB_TICKS - 1)) begin
                        stable_r[i] <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end
                if (!armed_r[i]) begin
                    if (!boot_r[1] || sync2_r[i]) begin
                        arm_cnt_r[i] <= '0;
                    end else if (tick_i) begin
                        if (arm_cnt_r[i] == DB_W'(DB_TICKS - 1)) begin
                            armed_r[i]   <= 1'b1;
                            arm_cnt_r[i] <= '0;
                        end else begin
                            arm_cnt_r[i] <= arm_cnt_r[i] + DB_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Event qualification: edges, button conflict and run-mode request
    always_comb begin
        rise_s      = stable_r[2:0] & ~stable_q_r & armed_r[2:0];
        conflict_s  = (stable_r[0] & stable_r[1]) | (stable_r[0] & stable_r[2]) |
                      (stable_r[1] & stable_r[2]);
        run_req_s   = stable_r[3] & armed_r[3] & ~at_top_i & ~stable_r[1] & ~stable_r[2];
        dir_held_s  = dir_r ? stable_r[1] : stable_r[0];
        timer_inc_s = (timer_r >= TMR_W'(TMR_MAX)) ? timer_r : timer_r + TMR_W'(1);
    end

    // Repeat FSM next-state and command outputs
    always_comb begin
        state_n  = state_r;
        dir_n    = dir_r;
        timer_n  = timer_r;
        fsm_up_s = 1'b0;
        fsm_dw_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!conflict_s && rise_s[0]) begin
                    fsm_up_s = 1'b1;
                    dir_n    = 1'b0;
                    timer_n  = '0;
                    state_n  = ST_HOLD;
                end else if (!conflict_s && rise_s[1]) begin
                    fsm_dw_s = 1'b1;
                    dir_n    = 1'b1;
                    timer_n  = '0;
                    state_n  = ST_HOLD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HOLD, ST_RPT: begin
                if (conflict_s || !dir_held_s) begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                end else if (tick_i) begin
                    if (timer_inc_s >= ((state_r == ST_HOLD) ? TMR_W'(RPT_DELAY)
                                                             : TMR_W'(RPT_PERIOD))) begin
                        fsm_up_s = ~dir_r;
                        fsm_dw_s = dir_r;
                        timer_n  = '0;
                        state_n  = ST_RPT;
                    end else begin
                        timer_n = timer_inc_s;
                    end
                end else begin
                    timer_n = timer_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
                timer_n = '0;
            end
        endcase
        up_n = ~conflict_s & (fsm_up_s | run_req_s);
        dw_n = ~conflict_s & fsm_dw_s;
        ld_n = ~conflict_s & rise_s[2];
    end

    // FSM state and registered command pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            dir_r   <= 1'b0;
            timer_r <= '0;
            up_o    <= 1'b0;
            dw_o    <= 1'b0;
            ld_o    <= 1'b0;
        end else begin
            state_r <= state_n;
            dir_r   <= dir_n;
            timer_r <= timer_n;
            up_o    <= up_n;
            dw_o    <= dw_n;
            ld_o    <= ld_n;
        end
    end

endmodule

// File: tb/tb_btn_cmd_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses (kind, cycle); a negedge monitor pops and checks.
module tb_btn_cmd_conditioner;

    logic       clk_i = 1'b0;
    logic       rst_ni, tick_i;
    logic       btn_up_i, btn_dw_i, btn_ld_i, btn_run_i, at_top_i;
    logic       up_o, dw_o, ld_o;
    logic [3:0] held_o;

    int unsigned cyc;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        logic [2:0]  kind;
        int unsigned cyc;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [2:0] K_UP = 3'b001;
    localparam logic [2:0] K_DW = 3'b010;
    localparam logic [2:0] K_LD = 3'b100;

    btn_cmd_conditioner #(.DB_TICKS(4), .RPT_DELAY(8), .RPT_PERIOD(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick_i),
        .btn_up_i(btn_up_i), .btn_dw_i(btn_dw_i), .btn_ld_i(btn_ld_i), .btn_run_i(btn_run_i),
        .at_top_i(at_top_i), .up_o(up_o), .dw_o(dw_o), .ld_o(ld_o), .held_o(held_o)
    );

    always #5 clk_i = ~clk_i;

    // Cycle counter; tick is high during the cycle following every edge with cyc % 4 == 0
    initial begin
        cyc    = 0;
        tick_i = 1'b0;
        forever begin
            @(posedge clk_i);
            cyc = cyc + 1;
            #1 tick_i = ((cyc % 4) == 0);
        end
    end

    // Monitor: every cycle with a command pulse must match the head of the scoreboard
    always @(negedge clk_i) begin
        exp_t       e;
        logic [2:0] got;
        got = {ld_o, dw_o, up_o};
        if (rst_ni === 1'b1 && got != 3'b000) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got kind=%b at cycle %0d, required no pulse", got, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== got || e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got kind=%b at cycle %0d, required kind=%b at cycle %0d",
                             got, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic wait_to(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic align(output int unsigned p);
        p = (cyc / 4 + 1) * 4;
        wait_to(p);
    endtask

    task automatic push(input logic [2:0] k, input int unsigned c);
        exp_q.push_back('{kind: k, cyc: c});
    endtask

    task automatic push_run(input int unsigned c0, input int unsigned c1);
        for (int unsigned c = c0; c <= c1; c++) push(K_UP, c);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic chk_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected pulses missing, next kind=%b at cycle %0d",
                     name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required self-finish");
        $fatal(1);
    end

    initial begin
        int unsigned p;
        int unsigned r;
        rst_ni = 1'b0; btn_up_i = 1'b0; btn_dw_i = 1'b0; btn_ld_i = 1'b0;
        btn_run_i = 1'b0; at_top_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("reset_up", up_o, 1'b0);
        chk("reset_dw", dw_o, 1'b0);
        chk("reset_ld", ld_o, 1'b0);
        chk("reset_held", held_o, 4'b0000);
        rst_ni = 1'b1;
        wait_to(cyc + 40);

        // Clean up press: first pulse 18 cycles after press, repeat 8 ticks later, then every 2
        align(p);
        btn_up_i = 1'b1;
        push(K_UP, p + 18); push(K_UP, p + 49); push(K_UP, p + 57);
        push(K_UP, p + 65); push(K_UP, p + 73); push(K_UP, p + 81);
        wait_to(p + 40);
        chk("up_held", held_o, 4'b0001);
        wait_to(p + 68);
        btn_up_i = 1'b0;
        wait_to(p + 120);
        chk("up_released", held_o, 4'b0000);
        chk_empty("up_repeat");

        // Bounce on dw shorter than the debounce window, then settled high for 6 ticks
        align(p);
        btn_dw_i = 1'b1; wait_to(p + 8);
        btn_dw_i = 1'b0; wait_to(p + 12);
        btn_dw_i = 1'b1; wait_to(p + 24);
        btn_dw_i = 1'b0; wait_to(p + 28);
        btn_dw_i = 1'b1; wait_to(p + 36);
        chk("bounce_held", held_o, 4'b0000);
        btn_dw_i = 1'b0; wait_to(p + 40);
        btn_dw_i = 1'b1;
        push(K_DW, p + 58);
        wait_to(p + 64);
        btn_dw_i = 1'b0;
        wait_to(p + 120);
        chk_empty("dw_bounce");

        // Long load press: exactly one pulse
        align(p);
        btn_ld_i = 1'b1;
        push(K_LD, p + 18);
        wait_to(p + 100);
        chk("ld_held", held_o, 4'b0100);
        wait_to(p + 200);
        btn_ld_i = 1'b0;
        wait_to(p + 240);
        chk_empty("ld_single");

        // Conflict: ld pressed while up repeats silences output; releasing ld does not resume
        align(p);
        btn_up_i = 1'b1;
        push(K_UP, p + 18); push(K_UP, p + 49); push(K_UP, p + 57);
        push(K_UP, p + 65); push(K_UP, p + 73);
        wait_to(p + 60);
        btn_ld_i = 1'b1;
        wait_to(p + 120);
        chk("conflict_held", held_o, 4'b0101);
        btn_ld_i = 1'b0;
        wait_to(p + 180);
        chk("conflict_up_only", held_o, 4'b0001);
        btn_up_i = 1'b0;
        wait_to(p + 220);
        chk_empty("conflict");
        align(r);
        btn_up_i = 1'b1;
        push(K_UP, r + 18);
        wait_to(r + 20);
        btn_up_i = 1'b0;
        wait_to(r + 80);
        chk_empty("conflict_repress");

        // Run mode: continuous up, blocked by at_top, overridden by a dw press
        align(p);
        btn_run_i = 1'b1;
        push_run(p + 18, p + 30);
        push_run(p + 41, p + 61);
        push(K_DW, p + 62);
        push_run(p + 82, p + 109);
        wait_to(p + 30);
        at_top_i = 1'b1;
        wait_to(p + 40);
        at_top_i = 1'b0;
        wait_to(p + 44);
        btn_dw_i = 1'b1;
        wait_to(p + 64);
        btn_dw_i = 1'b0;
        wait_to(p + 92);
        btn_run_i = 1'b0;
        wait_to(p + 140);
        chk_empty("run");

        // Reset mid-repeat: outputs drop at once; held press is discarded until re-pressed
        align(p);
        btn_up_i = 1'b1;
        push(K_UP, p + 18); push(K_UP, p + 49);
        wait_to(p + 57);
        chk("pre_reset_up", up_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("async_reset_up", up_o, 1'b0);
        chk("async_reset_held", held_o, 4'b0000);
        wait_to(p + 60);
        rst_ni = 1'b1;
        wait_to(p + 100);
        chk("post_reset_held", held_o, 4'b0001);
        wait_to(p + 140);
        chk_empty("reset_discard");
        btn_up_i = 1'b0;
        wait_to(p + 180);
        align(r);
        btn_up_i = 1'b1;
        push(K_UP, r + 18);
        wait_to(r + 20);
        btn_up_i = 1'b0;
        wait_to(r + 80);
        chk_empty("reset_repress");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
